// File: rtl/ir_pkg.sv
// ir_pkg: shared constants for the NEC IR decoder (state codes, counter width, default timing in us).
package ir_pkg;
  localparam int CNT_W = 14;
  localparam logic ACTIVE_LVL_DEF = 1'b0;
  localparam logic [CNT_W-1:0] LEAD_M_MIN_DEF = 14'd8000;
  localparam logic [CNT_W-1:0] LEAD_M_MAX_DEF = 14'd10000;
  localparam logic [CNT_W-1:0] LEAD_S_MIN_DEF = 14'd4000;
  localparam logic [CNT_W-1:0] LEAD_S_MAX_DEF = 14'd5000;
  localparam logic [CNT_W-1:0] REP_S_MIN_DEF  = 14'd1800;
  localparam logic [CNT_W-1:0] REP_S_MAX_DEF  = 14'd2700;
  localparam logic [CNT_W-1:0] BIT_M_MIN_DEF  = 14'd300;
  localparam logic [CNT_W-1:0] BIT_M_MAX_DEF  = 14'd900;
  localparam logic [CNT_W-1:0] ZERO_MAX_DEF   = 14'd900;
  localparam logic [CNT_W-1:0] ONE_MIN_DEF    = 14'd1300;
  localparam logic [CNT_W-1:0] ONE_MAX_DEF    = 14'd2000;
  localparam logic [CNT_W-1:0] TIMEOUT_DEF    = 14'd12000;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEAD_M = 3'd1;
  localparam logic [2:0] S_LEAD_S = 3'd2;
  localparam logic [2:0] S_BIT_M  = 3'd3;
  localparam logic [2:0] S_BIT_S  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_REP_M  = 3'd6;
  function automatic logic in_win(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] lo, input logic [CNT_W-1:0] hi);
    return c >= lo && c <= hi;
  endfunction
endpackage

// File: rtl/ir_nec_decoder_if.sv
// ir_nec_decoder_if: receiver level in, decoded frame and strobes out.
interface ir_nec_decoder_if;
  logic in;
  logic [15:0] addr;
  logic [7:0] cmd;
  logic valid;
  logic rpt;
  logic err;
  modport master (output in, input addr, input cmd, input valid, input rpt, input err);
  modport slave (input in, output addr, output cmd, output valid, output rpt, output err);
endinterface

// File: rtl/ir_pulse_timer.sv
// ir_pulse_timer: edge detection on the IR level and a saturating width counter cleared on every edge.
module ir_pulse_timer
  import ir_pkg::*;
#(
  parameter logic ACTIVE_LVL = ACTIVE_LVL_DEF
) (
  input  logic             clkus,
  input  logic             rstn,
  input  logic             in_lvl,
  output logic             mark_start,
  output logic             mark_end,
  output logic [CNT_W-1:0] cnt
);
  logic prev_q, prev_d, edge_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    edge_w = in_lvl != prev_q;
    prev_d = in_lvl;
    cnt_d = edge_w ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    mark_start = edge_w && in_lvl == ACTIVE_LVL;
    mark_end = edge_w && in_lvl != ACTIVE_LVL;
  end
  always_ff @(posedge clkus or negedge rstn)
    if (!rstn) begin
      prev_q <= ~ACTIVE_LVL;
      cnt_q <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q <= cnt_d;
    end
  assign cnt = cnt_q;
endmodule

// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder: NEC IR frame decoder producing addr/cmd and valid/rpt/err strobes.
// Define NEC_REPEAT_EN to recognise the repeat code; otherwise a repeat-length space is an error.
module ir_nec_decoder
  import ir_pkg::*;
#(
  parameter logic ACTIVE_LVL = ACTIVE_LVL_DEF,
  parameter logic [CNT_W-1:0] LEAD_M_MIN = LEAD_M_MIN_DEF,
  parameter logic [CNT_W-1:0] LEAD_M_MAX = LEAD_M_MAX_DEF,
  parameter logic [CNT_W-1:0] LEAD_S_MIN = LEAD_S_MIN_DEF,
  parameter logic [CNT_W-1:0] LEAD_S_MAX = LEAD_S_MAX_DEF,
`ifdef NEC_REPEAT_EN
  parameter logic [CNT_W-1:0] REP_S_MIN = REP_S_MIN_DEF,
  parameter logic [CNT_W-1:0] REP_S_MAX = REP_S_MAX_DEF,
`endif
  parameter logic [CNT_W-1:0] BIT_M_MIN = BIT_M_MIN_DEF,
  parameter logic [CNT_W-1:0] BIT_M_MAX = BIT_M_MAX_DEF,
  parameter logic [CNT_W-1:0] ZERO_MAX = ZERO_MAX_DEF,
  parameter logic [CNT_W-1:0] ONE_MIN = ONE_MIN_DEF,
  parameter logic [CNT_W-1:0] ONE_MAX = ONE_MAX_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT = TIMEOUT_DEF
) (
  input logic clkus,
  input logic rstn,
  ir_nec_decoder_if.slave bus
);
  logic mark_start, mark_end, rep_win, zero_w, one_w;
  logic [CNT_W-1:0] cnt;
  logic [2:0] state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0] bitcnt_q, bitcnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0] cmd_q, cmd_d;
  logic valid_q, valid_d, rpt_q, rpt_d, err_q, err_d;
  ir_pulse_timer #(.ACTIVE_LVL(ACTIVE_LVL)) u_timer (
    .clkus      (clkus),
    .rstn       (rstn),
    .in_lvl     (bus.in),
    .mark_start (mark_start),
    .mark_end   (mark_end),
    .cnt        (cnt)
  );
`ifdef NEC_REPEAT_EN
  assign rep_win = in_win(cnt, REP_S_MIN, REP_S_MAX);
`else
  assign rep_win = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bitcnt_d = bitcnt_q;
    addr_d = addr_q;
    cmd_d = cmd_q;
    valid_d = 1'b0;
    rpt_d = 1'b0;
    err_d = 1'b0;
    zero_w = in_win(cnt, BIT_M_MIN, ZERO_MAX);
    one_w = in_win(cnt, ONE_MIN, ONE_MAX);
    case (state_q)
      S_IDLE: state_d = mark_start ? S_LEAD_M : S_IDLE;
      S_LEAD_M: if (mark_end) begin
        state_d = S_LEAD_S;
        err_d = !in_win(cnt, LEAD_M_MIN, LEAD_M_MAX);
      end
      S_LEAD_S: if (mark_start) begin
        bitcnt_d = 5'd0;
        state_d = in_win(cnt, LEAD_S_MIN, LEAD_S_MAX) ? S_BIT_M : S_REP_M;
        err_d = !in_win(cnt, LEAD_S_MIN, LEAD_S_MAX) && !rep_win;
      end
      S_BIT_M: if (mark_end) begin
        state_d = S_BIT_S;
        err_d = !in_win(cnt, BIT_M_MIN, BIT_M_MAX);
      end
      S_BIT_S: if (mark_start) begin
        shift_d = {one_w, shift_q[31:1]};
        bitcnt_d = bitcnt_q + 5'd1;
        state_d = &bitcnt_q ? S_CHECK : S_BIT_M;
        err_d = !zero_w && !one_w;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        valid_d = shift_q[23:16] == ~shift_q[31:24];
        err_d = !valid_d;
        addr_d = valid_d ? shift_q[15:0] : addr_q;
        cmd_d = valid_d ? shift_q[23:16] : cmd_q;
      end
`ifdef NEC_REPEAT_EN
      S_REP_M: if (mark_end) begin
        state_d = S_IDLE;
        rpt_d = in_win(cnt, BIT_M_MIN, BIT_M_MAX);
        err_d = !rpt_d;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // A stalled line aborts any frame in progress; CHECK lasts one cycle so it never times out.
    if (state_q != S_IDLE && state_q != S_CHECK && cnt == TIMEOUT) err_d = 1'b1;
    if (err_d) state_d = S_IDLE;
  end
  always_ff @(posedge clkus or negedge rstn)
    if (!rstn) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bitcnt_q <= '0;
      addr_q <= '0;
      cmd_q <= '0;
      valid_q <= 1'b0;
      rpt_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bitcnt_q <= bitcnt_d;
      addr_q <= addr_d;
      cmd_q <= cmd_d;
      valid_q <= valid_d;
      rpt_q <= rpt_d;
      err_q <= err_d;
    end
  assign bus.addr = addr_q;
  assign bus.cmd = cmd_q;
  assign bus.valid = valid_q;
  assign bus.rpt = rpt_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb_ir_nec_decoder: directed and randomized NEC frames with timing scaled by 1/20 to keep runs short.
// A level held for w+1 clocks is measured by the decoder as a width of w.
`timescale 1ns/1ps
module tb_ir_nec_decoder;
  localparam int LM_MIN = 400, LM_MAX = 500, LS_MIN = 200, LS_MAX = 250;
  localparam int BM_MIN = 15, BM_MAX = 45, Z_MAX = 45, O_MIN = 65, O_MAX = 100, TO = 600;
  localparam logic MARK = 1'b0, SPACE = 1'b1;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  ir_nec_decoder_if bus();
  ir_nec_decoder #(
    .LEAD_M_MIN(14'd400), .LEAD_M_MAX(14'd500), .LEAD_S_MIN(14'd200), .LEAD_S_MAX(14'd250),
`ifdef NEC_REPEAT_EN
    .REP_S_MIN(14'd90), .REP_S_MAX(14'd135),
`endif
    .BIT_M_MIN(14'd15), .BIT_M_MAX(14'd45), .ZERO_MAX(14'd45),
    .ONE_MIN(14'd65), .ONE_MAX(14'd100), .TIMEOUT(14'd600)
  ) dut (
    .clkus (clk),
    .rstn  (rstn),
    .bus   (bus)
  );
  int n_cmp, n_bad, nv, nr, ne, err_cyc, cyc;
  logic [15:0] exp_addr;
  logic [7:0] exp_cmd;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rstn) begin
      if (bus.valid) nv <= nv + 1;
      if (bus.rpt) nr <= nr + 1;
      if (bus.err) begin
        ne <= ne + 1;
        err_cyc <= cyc;
      end
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic seg(input logic lvl, input int w);
    bus.in = lvl;
    repeat (w + 1) @(negedge clk);
  endtask
  function automatic int pick(input bit rnd, input int lo, input int hi, input int nom);
    return rnd ? int'($urandom_range(hi, lo)) : nom;
  endfunction
  // Leader, nbits data bits (stopping after a bad space at index bad), then a closing mark.
  task automatic frame(input logic [31:0] d, input int nbits, input int bad, input bit rnd);
    seg(MARK, pick(rnd, LM_MIN, LM_MAX, 450));
    seg(SPACE, pick(rnd, LS_MIN, LS_MAX, 225));
    for (int i = 0; i < nbits; i++) begin
      seg(MARK, pick(rnd, BM_MIN, BM_MAX, 28));
      if (i == bad) begin
        seg(SPACE, int'($urandom_range(O_MIN - 1, Z_MAX + 1)));
        break;
      end
      seg(SPACE, d[i] ? pick(rnd, O_MIN, O_MAX, 84) : pick(rnd, BM_MIN, Z_MAX, 28));
    end
    seg(MARK, 28);
  endtask
  task automatic counts(input string tag, input int v0, input int r0, input int e0, input int ev, input int er, input int ee);
    chk({tag, "_valid"}, nv - v0, ev);
    chk({tag, "_rpt"}, nr - r0, er);
    chk({tag, "_err"}, ne - e0, ee);
  endtask
  task automatic outs(input string tag);
    chk({tag, "_addr"}, bus.addr, exp_addr);
    chk({tag, "_cmd"}, bus.cmd, exp_cmd);
  endtask
  initial begin
    int v0, r0, e0, c0, bad;
    logic [31:0] d;
    bus.in = SPACE;
    repeat (3) @(negedge clk);
    exp_addr = '0;
    exp_cmd = '0;
    outs("reset");
    chk("reset_strobes", {bus.valid, bus.rpt, bus.err}, 3'b000);
    rstn = 1'b1;
    seg(SPACE, 20);
    v0 = nv; r0 = nr; e0 = ne;
    d = {8'hED, 8'h12, 16'h00FF};
    frame(d, 32, -1, 0);
    seg(SPACE, 60);
    counts("nominal", v0, r0, e0, 1, 0, 0);
    exp_addr = 16'h00FF;
    exp_cmd = 8'h12;
    outs("nominal");
    v0 = nv; r0 = nr; e0 = ne;
    frame(d ^ 32'h8000_0000, 32, -1, 0);
    seg(SPACE, 60);
    counts("badinv", v0, r0, e0, 0, 0, 1);
    outs("badinv");
    v0 = nv; r0 = nr; e0 = ne;
    seg(MARK, 450);
    seg(SPACE, 112);
    seg(MARK, 28);
    seg(SPACE, 60);
`ifdef NEC_REPEAT_EN
    counts("repeat", v0, r0, e0, 0, 1, 0);
`else
    counts("repeat", v0, r0, e0, 0, 0, 1);
`endif
    v0 = nv; r0 = nr; e0 = ne;
    seg(MARK, 350);
    seg(SPACE, 100);
    counts("shortlead", v0, r0, e0, 0, 0, 1);
    d = {8'h5A, 8'hA5, 16'hC3E1};
    frame(d, 32, -1, 0);
    seg(SPACE, 60);
    counts("afterlead", v0, r0, e0, 1, 0, 1);
    exp_addr = 16'hC3E1;
    exp_cmd = 8'hA5;
    outs("afterlead");
    v0 = nv; r0 = nr; e0 = ne;
    frame(32'h0F0F_1234, 20, -1, 0);
    bus.in = SPACE;
    c0 = cyc;
    for (int k = 0; k < 2 * TO && ne == e0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    // One clock to register the edge, one more to register the timeout strobe.
    chk("timeout_latency", err_cyc - c0, TO + 2);
    counts("timeout", v0, r0, e0, 0, 0, 1);
    v0 = nv; r0 = nr; e0 = ne;
    frame(32'h0000_0000, 10, -1, 0);
    counts("midframe", v0, r0, e0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    exp_addr = '0;
    exp_cmd = '0;
    outs("rst_mid");
    chk("rst_mid_strobes", {bus.valid, bus.rpt, bus.err}, 3'b000);
    @(negedge clk);
    bus.in = SPACE;
    rstn = 1'b1;
    seg(SPACE, 60);
    v0 = nv; r0 = nr; e0 = ne;
    d = {8'hB6, 8'h49, 16'h1F20};
    frame(d, 32, -1, 0);
    seg(SPACE, 60);
    counts("post_rst", v0, r0, e0, 1, 0, 0);
    exp_addr = 16'h1F20;
    exp_cmd = 8'h49;
    outs("post_rst");
    for (int n = 0; n < 6; n++) begin
      d[15:0] = 16'($urandom);
      d[23:16] = 8'($urandom);
      d[31:24] = ($urandom_range(2, 0) == 0) ? 8'($urandom) : ~d[23:16];
      bad = ($urandom_range(3, 0) == 0) ? int'($urandom_range(31, 0)) : -1;
      v0 = nv; r0 = nr; e0 = ne;
      frame(d, 32, bad, 1);
      seg(SPACE, 60);
      if (bad < 0 && d[31:24] == ~d[23:16]) begin
        counts($sformatf("rnd%0d", n), v0, r0, e0, 1, 0, 0);
        exp_addr = d[15:0];
        exp_cmd = d[23:16];
      end else counts($sformatf("rnd%0d", n), v0, r0, e0, 0, 0, 1);
      outs($sformatf("rnd%0d", n));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
